// File: rtl/wm_controller_if.sv
// Washing-machine controller signal bundle: sensor/timer inputs toward the
// controller and the exported 3-bit phase state back out.
interface wm_controller_if;
    logic       sig_Lid_Closed;
    logic       sig_Coin;
    logic       sig_Cancel;
    logic       sig_Time_Out;
    logic       sig_Out_Of_Balance;
    logic       sig_Motor_Failure;
    logic [2:0] state;

    modport master (
        output sig_Lid_Closed,
        output sig_Coin,
        output sig_Cancel,
        output sig_Time_Out,
        output sig_Out_Of_Balance,
        output sig_Motor_Failure,
        input  state
    );

    modport slave (
        input  sig_Lid_Closed,
        input  sig_Coin,
        input  sig_Cancel,
        input  sig_Time_Out,
        input  sig_Out_Of_Balance,
        input  sig_Motor_Failure,
        output state
    );
endinterface

// File: rtl/wm_controller.sv
// Washing-machine cycle controller: Moore FSM sequencing coin payment, soak,
// wash, rinse and spin; phase timing comes from an external timer pulse.
module wm_controller #(
    parameter int unsigned COINS_REQUIRED = 1
) (
    input  logic             clock,
    input  logic             reset,
    wm_controller_if.slave   bus
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READY   = 3'd1,
        S_SOAK    = 3'd2,
        S_WASH    = 3'd3,
        S_RINSE   = 3'd4,
        S_SPIN    = 3'd5,
        S_BALANCE = 3'd6,
        S_FAULT   = 3'd7
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;

    // State and coin count registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: motor failure, then cancel, then phase progression
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (bus.sig_Cancel) begin
                    count_d = '0;
                end else if (bus.sig_Coin) begin
                    if (count_q == CNT_W'(COINS_REQUIRED - 1)) begin
                        state_d = S_READY;
                        count_d = '0;
                    end else if (count_q < CNT_W'(COINS_REQUIRED)) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            S_READY: begin
                if (bus.sig_Cancel) begin
                    state_d = S_IDLE;
                end else if (bus.sig_Lid_Closed) begin
                    state_d = S_SOAK;
                end
            end
            S_SOAK, S_WASH, S_RINSE: begin
                if (bus.sig_Motor_Failure) begin
                    state_d = S_FAULT;
                end else if (bus.sig_Cancel) begin
                    state_d = S_SPIN;
                end else if (bus.sig_Lid_Closed && bus.sig_Time_Out) begin
                    // Phase order follows the encoding: soak, wash, rinse, spin
                    state_d = state_t'(state_q + 3'd1);
                end
            end
            S_SPIN: begin
                if (bus.sig_Motor_Failure) begin
                    state_d = S_FAULT;
                end else if (bus.sig_Out_Of_Balance || !bus.sig_Lid_Closed) begin
                    state_d = S_BALANCE;
                end else if (bus.sig_Time_Out) begin
                    state_d = S_IDLE;
                end
            end
            S_BALANCE: begin
                if (bus.sig_Motor_Failure) begin
                    state_d = S_FAULT;
                end else if (!bus.sig_Out_Of_Balance && bus.sig_Lid_Closed) begin
                    state_d = S_SPIN;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_wm_controller.sv
// Scoreboard bench for wm_controller: one instance with a single-coin price,
// one with a three-coin price, directed steps with hand-computed states.
module tb_wm_controller;

    logic clk;
    logic reset1;
    logic reset3;

    wm_controller_if if1 ();
    wm_controller_if if3 ();

    wm_controller #(.COINS_REQUIRED(1)) dut1 (
        .clock (clk),
        .reset (reset1),
        .bus   (if1.slave)
    );

    wm_controller #(.COINS_REQUIRED(3)) dut3 (
        .clock (clk),
        .reset (reset3),
        .bus   (if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        int         tag;
        logic [2:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   tag_cnt  = 0;

    // Monitor: the state output is valid every cycle, compared just after the edge
    always @(posedge clk) begin
        exp_t       e;
        logic [2:0] act;
        #1;
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = (e.sel == 3) ? if3.state : if1.state;
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL step%0d dut_coins%0d state=%0d expected=%0d",
                         e.tag, e.sel, act, e.exp);
            end
        end
    end

    task automatic drive_idle();
        if1.sig_Lid_Closed = 0; if1.sig_Coin = 0; if1.sig_Cancel = 0;
        if1.sig_Time_Out = 0; if1.sig_Out_Of_Balance = 0; if1.sig_Motor_Failure = 0;
        if3.sig_Lid_Closed = 0; if3.sig_Coin = 0; if3.sig_Cancel = 0;
        if3.sig_Time_Out = 0; if3.sig_Out_Of_Balance = 0; if3.sig_Motor_Failure = 0;
        reset1 = 0;
        reset3 = 0;
    endtask

    // One clock step on the selected instance; expected state is queued
    task automatic step(input int sel, input bit rst, input bit lid, input bit coin,
                        input bit cancel, input bit tout, input bit oob, input bit mf,
                        input logic [2:0] exp);
        exp_t e;
        @(negedge clk);
        drive_idle();
        if (sel == 3) begin
            reset3 = rst;
            if3.sig_Lid_Closed = lid; if3.sig_Coin = coin; if3.sig_Cancel = cancel;
            if3.sig_Time_Out = tout; if3.sig_Out_Of_Balance = oob; if3.sig_Motor_Failure = mf;
        end else begin
            reset1 = rst;
            if1.sig_Lid_Closed = lid; if1.sig_Coin = coin; if1.sig_Cancel = cancel;
            if1.sig_Time_Out = tout; if1.sig_Out_Of_Balance = oob; if1.sig_Motor_Failure = mf;
        end
        tag_cnt++;
        e.sel = sel;
        e.tag = tag_cnt;
        e.exp = exp;
        q.push_back(e);
    endtask

    initial begin
        drive_idle();
        reset1 = 1;
        reset3 = 1;
        //        sel rst lid coin can tout oob mf exp
        // Reset, pay, close lid
        step(1, 1, 0, 0, 0, 0, 0, 0, 3'd0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 3'd1);
        step(1, 0, 1, 0, 0, 0, 0, 0, 3'd2);
        // Full cycle
        step(1, 0, 1, 0, 0, 1, 0, 0, 3'd3);
        step(1, 0, 1, 0, 0, 1, 0, 0, 3'd4);
        step(1, 0, 1, 0, 0, 1, 0, 0, 3'd5);
        step(1, 0, 1, 0, 0, 1, 0, 0, 3'd0);
        // Lid open in WASH pauses the timer
        step(1, 0, 0, 1, 0, 0, 0, 0, 3'd1);
        step(1, 0, 1, 0, 0, 0, 0, 0, 3'd2);
        step(1, 0, 1, 0, 0, 1, 0, 0, 3'd3);
        step(1, 0, 0, 0, 0, 1, 0, 0, 3'd3);
        step(1, 0, 1, 0, 0, 1, 0, 0, 3'd4);
        step(1, 0, 1, 0, 0, 1, 0, 0, 3'd5);
        step(1, 0, 1, 0, 0, 1, 0, 0, 3'd0);
        // Cancel in READY, in SOAK, and together with timeout
        step(1, 0, 0, 1, 0, 0, 0, 0, 3'd1);
        step(1, 0, 1, 0, 1, 0, 0, 0, 3'd0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 3'd1);
        step(1, 0, 1, 0, 0, 0, 0, 0, 3'd2);
        step(1, 0, 1, 0, 1, 0, 0, 0, 3'd5);
        step(1, 0, 1, 0, 0, 1, 0, 0, 3'd0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 3'd1);
        step(1, 0, 1, 0, 0, 0, 0, 0, 3'd2);
        step(1, 0, 1, 0, 1, 1, 0, 0, 3'd5);
        // Cancel ignored in SPIN; imbalance and lid open pause spin
        step(1, 0, 1, 0, 1, 0, 0, 0, 3'd5);
        step(1, 0, 1, 0, 0, 0, 1, 0, 3'd6);
        step(1, 0, 1, 0, 0, 0, 1, 0, 3'd6);
        step(1, 0, 1, 0, 1, 1, 1, 0, 3'd6);
        step(1, 0, 1, 0, 0, 0, 0, 0, 3'd5);
        step(1, 0, 0, 0, 0, 1, 0, 0, 3'd6);
        step(1, 0, 1, 0, 0, 0, 0, 0, 3'd5);
        step(1, 0, 1, 0, 0, 1, 0, 0, 3'd0);
        // Fault beats cancel, is absorbing, and only reset leaves it
        step(1, 0, 0, 1, 0, 0, 0, 0, 3'd1);
        step(1, 0, 1, 0, 0, 0, 0, 0, 3'd2);
        step(1, 0, 1, 0, 0, 1, 0, 0, 3'd3);
        step(1, 0, 1, 0, 0, 1, 0, 0, 3'd4);
        step(1, 0, 1, 0, 1, 1, 0, 1, 3'd7);
        step(1, 0, 1, 1, 0, 1, 0, 0, 3'd7);
        step(1, 0, 1, 0, 1, 0, 0, 0, 3'd7);
        step(1, 1, 0, 0, 0, 0, 0, 0, 3'd0);
        // Three-coin price: counting, refund on cancel, coins ignored in READY
        step(3, 1, 0, 0, 0, 0, 0, 0, 3'd0);
        step(3, 0, 0, 1, 0, 0, 0, 0, 3'd0);
        step(3, 0, 0, 0, 0, 0, 0, 0, 3'd0);
        step(3, 0, 0, 1, 0, 0, 0, 0, 3'd0);
        step(3, 0, 0, 1, 0, 0, 0, 0, 3'd1);
        step(3, 0, 0, 1, 0, 0, 0, 0, 3'd1);
        step(3, 0, 0, 0, 1, 0, 0, 0, 3'd0);
        step(3, 0, 0, 1, 0, 0, 0, 0, 3'd0);
        step(3, 0, 0, 1, 0, 0, 0, 0, 3'd0);
        step(3, 0, 0, 0, 1, 0, 0, 0, 3'd0);
        step(3, 0, 0, 1, 0, 0, 0, 0, 3'd0);
        step(3, 0, 0, 1, 0, 0, 0, 0, 3'd0);
        step(3, 0, 0, 1, 0, 0, 0, 0, 3'd1);
        step(3, 0, 1, 0, 0, 0, 0, 0, 3'd2);

        @(negedge clk);
        drive_idle();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wm_controller.md
Name: wm_controller

Overview:
- Washing-machine cycle controller: a Moore FSM sequencing coin payment, soak, wash, rinse and spin.
- Timing comes from an external timer that pulses `sig_Time_Out` at the end of each timed phase.
- The 3-bit state encoding is exported directly on `state`, to drive phase actuators and display logic downstream.
- Single clock domain; no internal timers.

Parameters:
- COINS_REQUIRED, default 1: number of coin pulses (1..7) to accumulate before the cycle may start.

Ports:
- clock  input  1  rising-edge system clock
- reset  input  1  synchronous, active-high reset
- sig_Lid_Closed  input  1  1 = lid closed and latched
- sig_Coin  input  1  one pulse per sampled cycle = one coin inserted
- sig_Cancel  input  1  user cancel request (level, sampled each clock)
- sig_Time_Out  input  1  external phase timer expired (one-cycle pulse)
- sig_Out_Of_Balance  input  1  drum load unbalanced during spin
- sig_Motor_Failure  input  1  motor fault detected
- state  output  3  current FSM state (registered)

Behaviour:
State encoding:
- 0 IDLE, 1 READY, 2 SOAK, 3 WASH, 4 RINSE, 5 SPIN, 6 BALANCE, 7 FAULT.

Registers and reset:
- All registers update on the rising edge of `clock`.
- `reset`=1 at an edge: state<=0, coin count<=0. This applies from any state, including FAULT and mid-cycle.
- Output `state` is the state register itself: no combinational path from inputs, one-cycle latency for every transition.

Transition priority, highest first:
- reset
- motor failure
- cancel
- phase logic

Per-state rules (conditions evaluated on inputs sampled at the edge):
- IDLE: each edge with `sig_Coin`=1 increments the coin count, saturating at COINS_REQUIRED.
  - When the count is already COINS_REQUIRED-1 and `sig_Coin`=1 -> READY; count cleared.
  - `sig_Cancel` in IDLE clears the coin count (refund); state stays 0.
- READY: `sig_Cancel` -> IDLE. Else `sig_Lid_Closed`=1 -> SOAK. Else hold.
- SOAK, WASH, RINSE:
  - `sig_Motor_Failure` -> FAULT.
  - `sig_Cancel` -> SPIN (drain and spin out before stopping).
  - `sig_Lid_Closed`=0 -> hold state (paused); `sig_Time_Out` is ignored while the lid is open.
  - `sig_Time_Out`=1 -> next phase (SOAK->WASH->RINSE->SPIN).
- SPIN:
  - `sig_Motor_Failure` -> FAULT.
  - `sig_Out_Of_Balance`=1 or `sig_Lid_Closed`=0 -> BALANCE.
  - `sig_Time_Out`=1 -> IDLE (cycle complete).
  - Cancel is ignored in SPIN (already draining).
- BALANCE (spin paused):
  - `sig_Motor_Failure` -> FAULT.
  - When `sig_Out_Of_Balance`=0 and `sig_Lid_Closed`=1 -> SPIN. Else hold.
  - Time_Out and Cancel are ignored.
- FAULT: absorbing; only `reset` exits (to IDLE).

Simultaneous events:
- Motor failure beats cancel and timeout.
- Cancel beats timeout.
- In SPIN, out-of-balance/lid-open beats timeout.
- `sig_Coin` outside IDLE is ignored and not counted.

Test Plan:
- Reset then coin: reset=1 for 1 edge -> state=0. COINS_REQUIRED=1, `sig_Coin` pulse -> state=1 next edge. Lid=1 -> state=2.
- Full cycle: from state 2 with lid=1, pulse `sig_Time_Out` four times, one per phase -> state 3, 4, 5, then 0.
- Lid open during WASH (state=3): lid=0 plus Time_Out pulse -> stays 3. Lid=1 plus Time_Out -> 4.
- Cancel: in READY -> 0. In SOAK -> 5. In SOAK with Time_Out same edge -> 5 (cancel wins).
- Spin imbalance: state=5, Out_Of_Balance=1 -> 6. Held 6 while it stays 1. Clear it with lid=1 -> 5. Then Time_Out -> 0.
- Fault: state=4 with Motor_Failure=1 and Cancel=1 -> 7. Stays 7 despite Coin/Time_Out. Reset -> 0.
- Parameter: COINS_REQUIRED=3 -> two coin pulses keep state=0, third -> 1. Cancel after two coins -> count cleared, three more coins needed.
